// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ requesters.
// Optional WAIT watchdog with error response: define ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] REQ_B,
  input  logic [NUM_REQ*4-1:0]          REQ_FUN,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [OUT_WIDTH-1:0]          RSP_DATA,
  output logic                          RSP_ERR,
  output logic [OPER_WIDTH-1:0]         ALU_A,
  output logic [OPER_WIDTH-1:0]         ALU_B,
  output logic [3:0]                    ALU_FUN,
  output logic                          ALU_EN,
  input  logic [OUT_WIDTH-1:0]          ALU_OUT,
  input  logic                          ALU_OUT_VALID
);

  localparam int unsigned GW = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned FW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            r_state,     w_state_nxt;
  logic [GW-1:0]         r_last,      w_last_nxt;
  logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [OUT_WIDTH-1:0]  r_rsp_data,  w_rsp_data_nxt;
  logic [OPER_WIDTH-1:0] r_alu_a,     w_alu_a_nxt;
  logic [OPER_WIDTH-1:0] r_alu_b,     w_alu_b_nxt;
  logic [FW-1:0]         r_alu_fun,   w_alu_fun_nxt;
  logic                  r_alu_en,    w_alu_en_nxt;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [2:0]            r_wdog,      w_wdog_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
`endif

  logic [OPER_WIDTH-1:0] w_req_a   [NUM_REQ];
  logic [OPER_WIDTH-1:0] w_req_b   [NUM_REQ];
  logic [FW-1:0]         w_req_fun [NUM_REQ];
  logic                  w_found;
  logic [GW-1:0]         w_win;
  int unsigned           w_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_req_a[i]   = REQ_A[i*OPER_WIDTH +: OPER_WIDTH];
    assign w_req_b[i]   = REQ_B[i*OPER_WIDTH +: OPER_WIDTH];
    assign w_req_fun[i] = REQ_FUN[i*FW +: FW];
  end

  // Round-robin search starting just after the last grant
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_last) + 32'd1 + k) % NUM_REQ;
      if (!w_found && REQ_VALID[GW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = GW'(w_idx);
      end
    end
  end

  assign REQ_READY = (RST && (r_state == S_IDLE) && w_found) ?
                     (NUM_REQ'(1) << w_win) : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_fun_nxt   = r_alu_fun;
    w_alu_en_nxt    = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    w_wdog_nxt      = r_wdog;
    w_rsp_err_nxt   = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_alu_a_nxt   = w_req_a[w_win];
          w_alu_b_nxt   = w_req_b[w_win];
          w_alu_fun_nxt = w_req_fun[w_win];
          w_alu_en_nxt  = 1'b1;
          w_last_nxt    = w_win;
          w_state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        w_wdog_nxt  = 3'd0;
`endif
      end
      S_WAIT: begin
        if (ALU_OUT_VALID) begin
          w_rsp_data_nxt  = ALU_OUT;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_last;
          w_state_nxt     = S_IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
        end else if (r_wdog == 3'd3) begin
          // Fourth WAIT cycle without a result: answer with an error
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_last;
          w_state_nxt     = S_IDLE;
        end else begin
          w_wdog_nxt      = r_wdog + 3'd1;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_last      <= GW'(NUM_REQ - 1);
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_alu_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_fun   <= w_alu_fun_nxt;
      r_alu_en    <= w_alu_en_nxt;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wdog    <= 3'd0;
      r_rsp_err <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_nxt;
      r_rsp_err <= w_rsp_err_nxt;
    end
  end

  assign RSP_ERR = r_rsp_err;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = r_alu_en;

endmodule
